// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_arbiter : CPU / debug arbiter for the single-port data memory,
//                    with bounded debug burst locking and read-data routing.
// Revision 1.0
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] c_ST_ARB      = 1'b0;
  localparam logic [0:0] c_ST_DBG_LOCK = 1'b1;
  localparam logic       c_OWN_CPU     = 1'b0;
  localparam logic       c_OWN_DBG     = 1'b1;
  localparam logic [7:0] c_LOCK_MAX    = 8'(LOCK_MAX);

  logic [0:0]    r_state, w_stateNext;
  logic          r_lastOwner, w_lastOwnerNext;
  logic [7:0]    r_lockCnt, w_lockCntNext;
  logic          r_rdTagV, w_rdTagVNext;
  logic          r_rdTag, w_rdTagNext;
  logic [DW-1:0] r_cpuHold, r_dbgHold;
  logic          w_cpuWin, w_dbgWin;
  logic          w_cpuGnt, w_dbgGnt;
  logic          w_cpuRvalid, w_dbgRvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_ARB;
      r_lastOwner <= c_OWN_DBG;
      r_lockCnt   <= 8'd0;
      r_rdTagV    <= 1'b0;
      r_rdTag     <= c_OWN_CPU;
      r_cpuHold   <= '0;
      r_dbgHold   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_lastOwner <= w_lastOwnerNext;
      r_lockCnt   <= w_lockCntNext;
      r_rdTagV    <= w_rdTagVNext;
      r_rdTag     <= w_rdTagNext;
      if (w_cpuRvalid) r_cpuHold <= mem_rdata;
      if (w_dbgRvalid) r_dbgHold <= mem_rdata;
    end
  end

  always_comb begin
    w_cpuWin = 1'b0;
    w_dbgWin = 1'b0;
    // A saturated lock yields exactly one slot to a waiting CPU.
    if (r_state == c_ST_DBG_LOCK && dbg_req && dbg_lock) begin
      if (r_lockCnt == c_LOCK_MAX && cpu_req) w_cpuWin = 1'b1;
      else                                   w_dbgWin = 1'b1;
    end else if (cpu_req && dbg_req) begin
      w_cpuWin = (r_lastOwner == c_OWN_DBG);
      w_dbgWin = (r_lastOwner == c_OWN_CPU);
    end else begin
      w_cpuWin = cpu_req;
      w_dbgWin = dbg_req;
    end

    w_lastOwnerNext = r_lastOwner;
    if (w_cpuWin)      w_lastOwnerNext = c_OWN_CPU;
    else if (w_dbgWin) w_lastOwnerNext = c_OWN_DBG;

    w_rdTagVNext = (w_cpuWin & ~cpu_we) | (w_dbgWin & ~dbg_we);
    w_rdTagNext  = w_dbgWin;

    w_stateNext   = c_ST_ARB;
    w_lockCntNext = 8'd0;
    if (w_dbgWin && dbg_lock) begin
      w_stateNext = c_ST_DBG_LOCK;
      if (r_state == c_ST_ARB)          w_lockCntNext = 8'd1;
      else if (r_lockCnt == c_LOCK_MAX) w_lockCntNext = r_lockCnt;
      else                              w_lockCntNext = r_lockCnt + 8'd1;
    end
  end

  // Grants are masked while reset is held so the memory sees no access.
  always_comb begin
    w_cpuGnt  = w_cpuWin & reset;
    w_dbgGnt  = w_dbgWin & reset;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_cpuGnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (w_dbgGnt) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
    end
    w_cpuRvalid = r_rdTagV & (r_rdTag == c_OWN_CPU);
    w_dbgRvalid = r_rdTagV & (r_rdTag == c_OWN_DBG);
  end

  assign cpu_stall  = cpu_req & ~w_cpuGnt;
  assign dbg_gnt    = w_dbgGnt;
  assign cpu_rvalid = w_cpuRvalid;
  assign dbg_rvalid = w_dbgRvalid;
  assign cpu_rdata  = w_cpuRvalid ? mem_rdata : r_cpuHold;
  assign dbg_rdata  = w_dbgRvalid ? mem_rdata : r_dbgHold;

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 1024x16 data memory between two requesters: the CPU datapath data port and a debug/loader port.
- Grants at most one access per cycle and stalls the CPU while the debug port owns the memory.
- Routes one-cycle-latency read data back to the requester that issued the read.
- Supports bounded debug burst locking so program loads can run back-to-back without starving the CPU.

Parameters:
- AW, 10, memory address width.
- DW, 16, memory data width.
- LOCK_MAX, 8, maximum consecutive locked debug grants before forced release to a waiting CPU (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held stable with cpu_we/addr/wdata while cpu_stall=1.
- cpu_we  input  1  1=write, 0=read.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_stall  output  1  cpu_req & ~cpu_gnt; datapath holds PC/SP while high.
- cpu_rvalid  output  1  CPU read data valid (one-cycle pulse).
- cpu_rdata  output  DW  CPU read data.
- dbg_req  input  1  debug access request.
- dbg_we  input  1  debug write enable.
- dbg_lock  input  1  request to keep ownership on following cycles.
- dbg_addr  input  AW  debug address.
- dbg_wdata  input  DW  debug write data.
- dbg_gnt  output  1  debug access issued this cycle.
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DW  debug read data.
- mem_addr  output  AW  memory address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid the cycle after a read is issued.

Behaviour:
- Grant is combinational from the requests and registered state. cpu_gnt is internal; dbg_gnt is a port. At most one grant per cycle.
- Registered state:
  - last_owner (0=CPU, 1=DBG).
  - state: ARB or DBG_LOCK.
  - lock_cnt, 8 bits.
  - rd_tag_v and rd_tag (owner of the in-flight read).
  - cpu_hold and dbg_hold data registers.
- ARB state:
  - Only one requester active: it is granted.
  - Both active: the requester other than last_owner is granted (round-robin).
  - Granted access updates last_owner.
- Lock entry: dbg granted with dbg_lock=1 -> state DBG_LOCK, lock_cnt=1.
- DBG_LOCK state: dbg has absolute priority while dbg_req & dbg_lock.
  - Each granted cycle increments lock_cnt.
  - If lock_cnt==LOCK_MAX and cpu_req=1, the CPU is granted that cycle and state returns to ARB.
  - If lock_cnt==LOCK_MAX and cpu_req=0, dbg stays granted and lock_cnt saturates.
  - dbg_req=0 or dbg_lock=0 -> back to ARB in the same cycle; that cycle is arbitrated as in ARB.
- Memory drive:
  - mem_addr/mem_wdata are muxed from the granted requester.
  - mem_we = granted requester's we.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read sets rd_tag_v=1 and rd_tag=owner for the next cycle.
  - In that cycle the matching *_rvalid=1 and *_rdata=mem_rdata, and the value is captured into the hold register.
  - Outside rvalid, *_rdata shows the hold register (last returned value).
  - Writes never raise rvalid.
- Latency:
  - Ungranted-free request: issue same cycle, read data next cycle.
  - CPU behind a debug grant: stalled one cycle per lost arbitration; worst case LOCK_MAX cycles.
- Reset (asserted low, any time):
  - Clears state to ARB, last_owner=DBG (CPU wins the first conflict), lock_cnt=0, rd_tag_v=0, hold registers=0.
  - All outputs 0, except cpu_stall, which follows cpu_req combinationally.
  - A read in flight at reset produces no rvalid after release.
- Same-cycle requests to the same address: only the granted access occurs; the loser reissues next cycle and sees the winner's write.

Test Plan:
- Reset low, then high; cpu_req=1, we=0, addr=0x005 with mem[5]=0x1234 -> mem_addr=0x005 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x1234, dbg_rvalid=0.
- cpu and dbg both request reads every cycle, no lock -> grants alternate CPU, DBG, CPU, DBG starting with CPU; cpu_stall=1 exactly on DBG cycles; each rvalid goes to the correct side with the correct data.
- dbg writes 0xBEEF to 0x3FE while CPU reads 0x3FE in the same cycle, starting after reset -> CPU granted first (reads old value); DBG writes next cycle; CPU reread returns 0xBEEF.
- dbg_lock=1, dbg_req=1 continuous, cpu_req=1 from cycle 0, LOCK_MAX=8 -> 8 consecutive dbg_gnt, then one CPU grant, then lock re-entered; cpu_stall high exactly 8 cycles.
- dbg locked burst with cpu_req=0 for 20 cycles -> dbg_gnt held 20 cycles, lock_cnt saturates; cpu_req raised -> CPU granted on the next cycle.
- CPU read issued, reset pulsed low before the next edge -> no cpu_rvalid after release; cpu_rdata=0; first post-reset conflict goes to CPU.
